wb_port_arbiter: RTL

Write-back port arbiter that drives the core's single register-file write port (WriteReg/WriteData/RegWrEn). It merges the in-order pipeline write-back stream with results from the multi-cycle multiply/divide unit (MDU), buffering MDU results in a small FIFO while the pipeline holds the port. It also keeps a per-register pending scoreboard so the hazard unit can stall readers of registers that still await an MDU result.

---
 rtl/wb_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back (latency 1, never stalled) has priority over
// a DEPTH-entry MDU result FIFO (earliest latency 2); mdu_ready_o drops while the FIFO is full.
module wb_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  input  logic        mdu_issue_i,
  input  logic [4:0]  mdu_issue_rd_i,
  output logic [31:0] pend_o,
  output logic [4:0]  WriteReg_o,
  output logic [31:0] WriteData_o,
  output logic        RegWrEn_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    fifo_rd_q  [DEPTH];
  logic [4:0]    fifo_rd_d  [DEPTH];
  logic [31:0]   fifo_dat_q [DEPTH];
  logic [31:0]   fifo_dat_d [DEPTH];
  logic [31:0]   pend_q, pend_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          push, pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_dat;

  // Ready depends on occupancy only, so a full FIFO never accepts in the cycle it pops.
  assign mdu_ready_o = (count_q < CW'(DEPTH));
  assign push        = mdu_valid_i && mdu_ready_o;
  assign pop         = !pipe_valid_i && (count_q != '0);
  assign head_rd     = fifo_rd_q[rd_ptr_q];
  assign head_dat    = fifo_dat_q[rd_ptr_q];

  always_comb begin
    fifo_rd_d  = fifo_rd_q;
    fifo_dat_d = fifo_dat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]  = mdu_rd_i;
      fifo_dat_d[wr_ptr_q] = mdu_data_i;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new issue to the register being retired wins over the clear.
  always_comb begin
    pend_d = pend_q;
    if (pop && (head_rd != 5'd0)) pend_d[head_rd] = 1'b0;
    if (mdu_issue_i && (mdu_issue_rd_i != 5'd0)) pend_d[mdu_issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    wen_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (pipe_valid_i) begin
      wen_d   = (pipe_rd_i != 5'd0);
      wreg_d  = pipe_rd_i;
      wdata_d = pipe_data_i;
    end else if (pop) begin
      wen_d   = (head_rd != 5'd0);
      wreg_d  = head_rd;
      wdata_d = head_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      wen_q    <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]  <= '0;
        fifo_dat_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      wen_q      <= wen_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_dat_q <= fifo_dat_d;
    end
  end

  assign pend_o      = pend_q;
  assign WriteReg_o  = wreg_q;
  assign WriteData_o = wdata_q;
  assign RegWrEn_o   = wen_q;

endmodule
